ram_dp_init: RTL and testbench

- Parametrised dual-port synchronous RAM; successor to the single-port program RAM.
- Port A: read/write data port (core load/store and loader). Port B: read-only instruction-fetch port.
- Adds asynchronous reset, hardware memory clear (reset or on request), ready/valid read handshake, A-write to B-read forwarding and out-of-range protection.
- Sits between core fetch/execute stages and the program loader.

---
 rtl/ram_dp_pkg.sv | 33 +++
 rtl/ram_dp_core.sv | 49 ++++
 rtl/ram_dp_init.sv | 184 ++++++++++++++++++
 tb/tb_ram_dp_init.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// ============================================================================
// Module : ram_dp_pkg
// Brief  : Shared types, default geometry and the parity helper for the
//          dual-port initialised program RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_dp_pkg;

  // Instruction word layout: opcode field followed by operand field
  localparam int OPCODE_WIDTH  = 14;
  localparam int OPERAND_WIDTH = 8;

  // Default geometry
  localparam int DEF_DATA_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_ADDR_WIDTH = 10;

  // Controller states: CLEAR sweeps the array, RUN serves requests
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Even-parity bit for up to 64 data bits (callers zero-extend narrower words)
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dp_core.sv
// ============================================================================
// Module : ram_dp_core
// Brief  : Bare two-port array: one write port, two registered read ports.
//          Port A read is read-first against a same-address write. Read
//          registers clear on reset so the wrapper's outputs start at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dp_core #(
  parameter int WORD_WIDTH = 22,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  a_re,
  input  logic [ADDR_WIDTH-1:0] a_raddr,
  output logic [WORD_WIDTH-1:0] a_rdata,
  input  logic                  b_re,
  input  logic [ADDR_WIDTH-1:0] b_raddr,
  output logic [WORD_WIDTH-1:0] b_rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Array write; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Port A read register; non-blocking read sees the pre-write word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    a_rdata <= '0;
    else if (a_re) a_rdata <= mem[a_raddr];
  end

  // Port B read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    b_rdata <= '0;
    else if (b_re) b_rdata <= mem[b_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/ram_dp_init.sv
// ============================================================================
// Module : ram_dp_init
// Brief  : Dual-port program RAM with hardware clear, ready gating, A-write
//          to B-read forwarding and out-of-range protection.
//          Optional macro RAM_DP_INIT_PARITY_EN adds one even-parity bit per
//          word and the a_perr/b_perr outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dp_init
  import ram_dp_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  a_wr_en,
  input  logic                  a_rd_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_rd_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
`ifdef RAM_DP_INIT_PARITY_EN
  output logic                  a_perr,
  output logic                  b_perr,
`endif
  output logic                  addr_err
);

`ifdef RAM_DP_INIT_PARITY_EN
  localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    clearing;

  logic                    a_oor, b_oor;
  logic                    a_rd_acc, b_rd_acc, a_wr_ok, fwd, err_nxt;
  logic [WORD_WIDTH-1:0]   init_word, a_word;
  logic                    core_we;
  logic [ADDR_WIDTH-1:0]   core_waddr;
  logic [WORD_WIDTH-1:0]   core_wdata;
  logic [WORD_WIDTH-1:0]   a_word_q, b_word_q;

  logic                    a_oor_q, b_oor_q, b_fwd_q;
  logic [DATA_WIDTH-1:0]   b_fwd_data;

  // Clear/run controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: sweep every word once, then serve; clr_req restarts the sweep
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_ADDR) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clearing = (state == ST_CLEAR);
  assign ready    = (state == ST_RUN);

  // Request qualification; nothing is accepted while the sweep runs
  assign a_oor    = ({1'b0, a_addr} >= DEPTH_LIM);
  assign b_oor    = ({1'b0, b_addr} >= DEPTH_LIM);
  assign a_rd_acc = ready & a_rd_en;
  assign b_rd_acc = ready & b_rd_en;
  assign a_wr_ok  = ready & a_wr_en & ~a_oor;
  assign fwd      = a_wr_ok & b_rd_acc & ~b_oor & (a_addr == b_addr);
  assign err_nxt  = ready & (((a_wr_en | a_rd_en) & a_oor) | (b_rd_en & b_oor));

`ifdef RAM_DP_INIT_PARITY_EN
  assign init_word = {even_parity(64'(INIT_VALUE)), INIT_VALUE};
  assign a_word    = {even_parity(64'(a_wdata)), a_wdata};
`else
  assign init_word = INIT_VALUE;
  assign a_word    = a_wdata;
`endif

  // The single write port is shared between the sweep and port A
  assign core_we    = clearing | a_wr_ok;
  assign core_waddr = clearing ? cnt : a_addr;
  assign core_wdata = clearing ? init_word : a_word;

  ram_dp_core #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (core_we),
    .waddr   (core_waddr),
    .wdata   (core_wdata),
    .a_re    (a_rd_acc & ~a_oor),
    .a_raddr (a_addr),
    .a_rdata (a_word_q),
    .b_re    (b_rd_acc & ~b_oor & ~fwd),
    .b_raddr (b_addr),
    .b_rdata (b_word_q)
  );

  // Read-side bookkeeping: source selects only move on an accepted read so
  // rdata holds its last value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      addr_err   <= 1'b0;
      a_oor_q    <= 1'b0;
      b_oor_q    <= 1'b0;
      b_fwd_q    <= 1'b0;
      b_fwd_data <= '0;
    end else begin
      a_rvalid <= a_rd_acc;
      b_rvalid <= b_rd_acc;
      addr_err <= err_nxt;
      if (a_rd_acc) a_oor_q <= a_oor;
      if (b_rd_acc) begin
        b_oor_q <= b_oor;
        b_fwd_q <= fwd;
      end
      if (fwd) b_fwd_data <= a_wdata;
    end
  end

  assign a_rdata = a_oor_q ? INIT_VALUE : a_word_q[DATA_WIDTH-1:0];
  assign b_rdata = b_oor_q ? INIT_VALUE :
                   b_fwd_q ? b_fwd_data : b_word_q[DATA_WIDTH-1:0];

`ifdef RAM_DP_INIT_PARITY_EN
  // Parity is checked on the stored word only; range-miss and forwarded
  // data never came from the array
  assign a_perr = a_rvalid & ~a_oor_q &
                  (even_parity(64'(a_word_q[DATA_WIDTH-1:0])) != a_word_q[DATA_WIDTH]);
  assign b_perr = b_rvalid & ~b_oor_q & ~b_fwd_q &
                  (even_parity(64'(b_word_q[DATA_WIDTH-1:0])) != b_word_q[DATA_WIDTH]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_init.sv
// ============================================================================
// Module : tb_ram_dp_init
// Brief  : Randomised scoreboard bench for ram_dp_init (DEPTH=1000 so the
//          range check sees a non-power-of-two limit). Build with
//          RAM_DP_INIT_PARITY_EN to include the parity scenario.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_dp_init;

  localparam int              DW    = 22;
  localparam int              DEPTH = 1000;
  localparam int              AW    = 10;
  localparam logic [DW-1:0]   INIT  = 22'h12345;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          ready;
  logic          a_wr_en = 1'b0, a_rd_en = 1'b0, b_rd_en = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, addr_err;
`ifdef RAM_DP_INIT_PARITY_EN
  logic          a_perr, b_perr;
`endif

  ram_dp_init #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INIT_VALUE (INIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .a_wr_en  (a_wr_en),
    .a_rd_en  (a_rd_en),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .b_rd_en  (b_rd_en),
    .b_addr   (b_addr),
    .b_rdata  (b_rdata),
    .b_rvalid (b_rvalid),
`ifdef RAM_DP_INIT_PARITY_EN
    .a_perr   (a_perr),
    .b_perr   (b_perr),
`endif
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    logic          perr;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  int            qe[$];
  logic [DW-1:0] mm  [DEPTH];
  bit            bad [DEPTH];
  bit            m_ready    = 1'b0;
  int            clear_left = DEPTH;
  int            cyc        = 0;
  logic [DW-1:0] last_a = '0, last_b = '0;
  int            n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i]  = INIT;
      bad[i] = 1'b0;
    end
  endtask

  // One clock: apply the spec rules to the inputs sampled at this edge
  task automatic tick();
    int   aa, ba;
    bit   aoor, boor;
    exp_t e;
    @(posedge clk);
    cyc++;
    aa   = int'(a_addr);
    ba   = int'(b_addr);
    aoor = (aa >= DEPTH);
    boor = (ba >= DEPTH);
    if (m_ready) begin
      if (a_rd_en) begin
        e.cyc  = cyc;
        e.data = aoor ? INIT : mm[aa];
        e.perr = !aoor && bad[aa];
        qa.push_back(e);
      end
      if (b_rd_en) begin
        e.cyc = cyc;
        if (boor) begin
          e.data = INIT; e.perr = 1'b0;
        end else if (a_wr_en && !aoor && aa == ba) begin
          e.data = a_wdata; e.perr = 1'b0;
        end else begin
          e.data = mm[ba]; e.perr = bad[ba];
        end
        qb.push_back(e);
      end
      if (((a_wr_en || a_rd_en) && aoor) || (b_rd_en && boor)) qe.push_back(cyc);
      if (a_wr_en && !aoor) begin
        mm[aa]  = a_wdata;
        bad[aa] = 1'b0;
      end
      if (clr_req) begin
        m_ready    = 1'b0;
        clear_left = DEPTH;
        model_clear();
      end
    end else begin
      if (clr_req) clear_left = DEPTH;
      else         clear_left--;
      if (clear_left == 0) m_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic op(input bit wr, input bit rd, input int aa, input logic [DW-1:0] wd,
                    input bit brd, input int ba, input bit clr);
    a_wr_en = wr;
    a_rd_en = rd;
    a_addr  = AW'(aa);
    a_wdata = wd;
    b_rd_en = brd;
    b_addr  = AW'(ba);
    clr_req = clr;
    tick();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return $urandom_range(0, 15);
      2:       return $urandom_range(0, 1023);
      default: return $urandom_range(990, 1023);
    endcase
  endfunction

  task automatic rand_op();
    op(1'($urandom), 1'($urandom), rand_addr(), DW'($urandom),
       1'($urandom), rand_addr(), 1'b0);
  endtask

  task automatic run_until_ready();
    for (int i = 0; i < DEPTH + 10 && !m_ready; i++) rand_op();
  endtask

  // Asynchronous reset in the middle of the low clock phase
  task automatic do_reset();
    #2;
    rst_n   = 1'b0;
    a_wr_en = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0; clr_req = 1'b0;
    #1;
    chk("rst_ready",    ready,    1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_rdata",  a_rdata,  '0);
    chk("rst_b_rdata",  b_rdata,  '0);
    chk("rst_addr_err", addr_err, 1'b0);
`ifdef RAM_DP_INIT_PARITY_EN
    chk("rst_a_perr",   a_perr,   1'b0);
    chk("rst_b_perr",   b_perr,   1'b0);
`endif
    qa.delete(); qb.delete(); qe.delete();
    last_a     = '0;
    last_b     = '0;
    m_ready    = 1'b0;
    clear_left = DEPTH;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    chk("ready", ready, m_ready);

    ev = (qa.size() > 0) && (qa[0].cyc == cyc);
    chk("a_rvalid", a_rvalid, ev);
    if (ev) begin
      e = qa.pop_front();
      chk("a_rdata", a_rdata, e.data);
      last_a = e.data;
`ifdef RAM_DP_INIT_PARITY_EN
      chk("a_perr", a_perr, e.perr);
`endif
    end else begin
      chk("a_rdata_hold", a_rdata, last_a);
    end

    ev = (qb.size() > 0) && (qb[0].cyc == cyc);
    chk("b_rvalid", b_rvalid, ev);
    if (ev) begin
      e = qb.pop_front();
      chk("b_rdata", b_rdata, e.data);
      last_b = e.data;
`ifdef RAM_DP_INIT_PARITY_EN
      chk("b_perr", b_perr, e.perr);
`endif
    end else begin
      chk("b_rdata_hold", b_rdata, last_b);
    end

    ev = (qe.size() > 0) && (qe[0] == cyc);
    chk("addr_err", addr_err, ev);
    if (ev) void'(qe.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // Requests during the initial sweep must be ignored
    run_until_ready();

    // Whole array reads back INIT on both ports
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, i, '0, 1'b1, DEPTH - 1 - i, 1'b0);

    // Write then read on the other port next cycle
    op(1'b1, 1'b0, 7, 22'h2A5A5, 1'b0, 0, 1'b0);
    op(1'b0, 1'b0, 0, '0, 1'b1, 7, 1'b0);

    // Same-cycle write/read: A read-first, B write-first
    op(1'b1, 1'b0, 12, 22'h3ABCD, 1'b0, 0, 1'b0);
    op(1'b1, 1'b1, 12, 22'h00123, 1'b1, 12, 1'b0);
    op(1'b0, 1'b1, 12, '0, 1'b0, 0, 1'b0);

    // Out-of-range write is dropped; read returns INIT
    op(1'b1, 1'b0, 1010, 22'h3FFFF, 1'b0, 0, 1'b0);
    op(1'b0, 1'b1, 1010, '0, 1'b0, 0, 1'b0);
    op(1'b0, 1'b0, 0, '0, 1'b1, 999, 1'b0);
    op(1'b0, 1'b0, 0, '0, 1'b1, 1000, 1'b0);
    idle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) rand_op();

    // clr_req wipes contents; clr_req inside CLEAR and a reset mid-sweep restart it
    op(1'b1, 1'b0, 5, 22'h0ABCD, 1'b0, 0, 1'b0);
    op(1'b0, 1'b1, 5, '0, 1'b1, 5, 1'b0);
    op(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 300; i++) rand_op();
    op(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 200; i++) rand_op();
    do_reset();
    run_until_ready();
    op(1'b0, 1'b1, 5, '0, 1'b1, 5, 1'b0);

    // Reset while running: outputs drop at once, then a fresh sweep
    for (int i = 0; i < 200; i++) rand_op();
    op(1'b1, 1'b1, 9, 22'h1F0F0, 1'b1, 9, 1'b0);
    do_reset();
    run_until_ready();
    op(1'b0, 1'b1, 9, '0, 1'b1, 9, 1'b0);

`ifdef RAM_DP_INIT_PARITY_EN
    // Corrupt one stored bit behind the controller's back
    op(1'b1, 1'b0, 3, 22'h2A5A5, 1'b0, 0, 1'b0);
    op(1'b1, 1'b0, 4, 22'h15A5A, 1'b0, 0, 1'b0);
    dut.u_core.mem[3][0] = ~dut.u_core.mem[3][0];
    mm[3][0] = ~mm[3][0];
    bad[3]   = 1'b1;
    op(1'b0, 1'b1, 4, '0, 1'b1, 3, 1'b0);
    op(1'b0, 1'b1, 3, '0, 1'b1, 4, 1'b0);
    idle();
`endif

    for (int i = 0; i < 300; i++) rand_op();
    repeat (3) idle();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qe_drained", qe.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
